// File: rtl/bidiag_band_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bidiag_band_extract_pkg
// Description : Shared types and constants for the bidiagonal band extractor.
//               Holds the default component width and matrix dimension, the
//               band position tags, the controller state encoding and the
//               band_slot() helper that maps a row-major element index onto
//               its band position.
// Revision    : 1.0 - initial release
// ============================================================================
package bidiag_band_extract_pkg;

    localparam int BIT_NUM = 18;
    localparam int DIM     = 4;

    // Band positions in emission order: d0,e0,d1,e1,d2,e2,d3
    localparam logic [2:0] TAG_D0 = 3'd0;
    localparam logic [2:0] TAG_E0 = 3'd1;
    localparam logic [2:0] TAG_D1 = 3'd2;
    localparam logic [2:0] TAG_E1 = 3'd3;
    localparam logic [2:0] TAG_D2 = 3'd4;
    localparam logic [2:0] TAG_E2 = 3'd5;
    localparam logic [2:0] TAG_D3 = 3'd6;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] tag;
    } band_slot_t;

    // Element k = DIM*row + col is in the band when it sits on the diagonal
    // or the superdiagonal. Its band position is 2*row + (col - row), which
    // equals the number of band elements preceding it in row-major order.
    function automatic band_slot_t band_slot(input int unsigned k);
        int unsigned row;
        int unsigned col;
        band_slot_t  slot;
        row        = k / DIM;
        col        = k % DIM;
        slot.valid = (col == row) || (col == row + 1);
        slot.tag   = 3'(row + col);
        return slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bidiag_band_extract_abs_sat.sv
`default_nettype none
// ============================================================================
// Module      : bidiag_band_extract_abs_sat
// Description : Saturating two's complement magnitude. The most negative
//               input maps to the largest positive value so the result fits
//               in WIDTH-1 unsigned bits.
// Ports       : x   - signed input, WIDTH bits
//               mag - unsigned magnitude, WIDTH-1 bits
// Revision    : 1.0 - initial release
// ============================================================================
module bidiag_band_extract_abs_sat
    import bidiag_band_extract_pkg::*;
#(
    parameter int WIDTH = BIT_NUM
) (
    input  logic signed [WIDTH-1:0] x,
    output logic        [WIDTH-2:0] mag
);

    logic [WIDTH-2:0] w_negated;

    always_comb begin
        w_negated = (~x[WIDTH-2:0]) + 1'b1;
        if (x[WIDTH-1] && (x[WIDTH-2:0] == '0)) begin
            mag = '1;
        end else if (x[WIDTH-1]) begin
            mag = w_negated;
        end else begin
            mag = x[WIDTH-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bidiag_band_extract.sv
`default_nettype none
// ============================================================================
// Module      : bidiag_band_extract
// Description : Collects a DIM*DIM row-major complex frame from the
//               bidiagonalization engine, keeps the band elements
//               (d0,e0,d1,e1,d2,e2,d3) and replays them on a ready/valid
//               stream. Tracks the largest residual magnitude left outside
//               the band and flags frames whose residual exceeds RESID_TH.
// Ports       : clk, rst_n              - clock, async active-low reset
//               s_valid, s_r, s_i       - upstream beats, no backpressure
//               m_valid, m_ready        - band element handshake
//               m_r, m_i, m_tag, m_last - band element payload
//               resid_max, resid_flag   - residual of last completed frame
//               frame_err               - pulse: short frame aborted
//               drop                    - pulse: frame arrived while emitting
// Revision    : 1.0 - initial release
// ============================================================================
module bidiag_band_extract #(
    parameter int                          BIT_NUM  = bidiag_band_extract_pkg::BIT_NUM,
    parameter int                          DIM      = bidiag_band_extract_pkg::DIM,
    parameter logic [BIT_NUM-1:0]          RESID_TH = 18'd64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic signed [BIT_NUM-1:0] s_r,
    input  logic signed [BIT_NUM-1:0] s_i,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [BIT_NUM-1:0] m_r,
    output logic signed [BIT_NUM-1:0] m_i,
    output logic [2:0]                m_tag,
    output logic                      m_last,
    output logic [BIT_NUM-2:0]        resid_max,
    output logic                      resid_flag,
    output logic                      frame_err,
    output logic                      drop
);

    import bidiag_band_extract_pkg::*;

    localparam int NBEAT = DIM * DIM;
    localparam int CNT_W = $clog2(NBEAT);
    localparam int NBAND = 2 * DIM - 1;
    localparam int MAG_W = BIT_NUM - 1;
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NBEAT - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_ptr;
    logic signed [BIT_NUM-1:0] r_store_r [NBAND];
    logic signed [BIT_NUM-1:0] r_store_i [NBAND];
    logic [MAG_W-1:0]          r_acc;
    logic                      r_in_burst;

    logic [MAG_W-1:0]          w_abs_r;
    logic [MAG_W-1:0]          w_abs_i;
    logic [MAG_W-1:0]          w_contrib;
    logic [MAG_W-1:0]          w_acc_next;
    band_slot_t                w_slot;
    logic [2:0]                w_ptr_nxt;

    bidiag_band_extract_abs_sat #(.WIDTH(BIT_NUM)) u_abs_r (
        .x   (s_r),
        .mag (w_abs_r)
    );

    bidiag_band_extract_abs_sat #(.WIDTH(BIT_NUM)) u_abs_i (
        .x   (s_i),
        .mag (w_abs_i)
    );

    // Band beats only leak energy through their imaginary part; off-band
    // beats contribute both components. Beat 0 restarts the running max.
    always_comb begin
        w_slot    = band_slot(32'(r_cnt));
        w_ptr_nxt = r_ptr + 3'd1;
        if (w_slot.valid) begin
            w_contrib = w_abs_i;
        end else begin
            w_contrib = (w_abs_r > w_abs_i) ? w_abs_r : w_abs_i;
        end
        if ((r_cnt == '0) || (w_contrib > r_acc)) begin
            w_acc_next = w_contrib;
        end else begin
            w_acc_next = r_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_COLLECT;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_acc      <= '0;
            r_in_burst <= 1'b0;
            for (int n = 0; n < NBAND; n++) begin
                r_store_r[n] <= '0;
                r_store_i[n] <= '0;
            end
            m_valid    <= 1'b0;
            m_r        <= '0;
            m_i        <= '0;
            m_tag      <= '0;
            m_last     <= 1'b0;
            resid_max  <= '0;
            resid_flag <= 1'b0;
            frame_err  <= 1'b0;
            drop       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            drop      <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (s_valid) begin
                        if (w_slot.valid) begin
                            r_store_r[w_slot.tag] <= s_r;
                            r_store_i[w_slot.tag] <= s_i;
                        end
                        r_acc <= w_acc_next;
                        if (r_cnt == C_LAST_BEAT) begin
                            r_cnt      <= '0;
                            resid_max  <= w_acc_next;
                            resid_flag <= ({1'b0, w_acc_next} > RESID_TH);
                            r_state    <= ST_EMIT;
                            r_ptr      <= '0;
                            r_in_burst <= 1'b0;
                            // d0 arrives on beat 0, so its slot is already
                            // written by the time the last beat lands.
                            m_valid    <= 1'b1;
                            m_r        <= r_store_r[0];
                            m_i        <= r_store_i[0];
                            m_tag      <= TAG_D0;
                            m_last     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_cnt != '0) begin
                        frame_err <= 1'b1;
                        r_cnt     <= '0;
                    end
                end

                ST_EMIT: begin
                    // First beat of any burst seen while emitting is a
                    // discarded frame; this includes a burst starting in
                    // the very cycle emission completes.
                    r_in_burst <= s_valid;
                    if (s_valid && !r_in_burst) begin
                        drop <= 1'b1;
                    end
                    if (m_ready) begin
                        if (r_ptr == TAG_D3) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_r     <= '0;
                            m_i     <= '0;
                            m_tag   <= '0;
                            r_ptr   <= '0;
                            r_state <= s_valid ? ST_DROP : ST_COLLECT;
                        end else begin
                            r_ptr  <= w_ptr_nxt;
                            m_r    <= r_store_r[w_ptr_nxt];
                            m_i    <= r_store_i[w_ptr_nxt];
                            m_tag  <= w_ptr_nxt;
                            m_last <= (w_ptr_nxt == TAG_D3);
                        end
                    end
                end

                ST_DROP: begin
                    if (!s_valid) begin
                        r_state <= ST_COLLECT;
                    end
                end

                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bidiag_band_extract.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bidiag_band_extract
// Description : Self-checking bench for bidiag_band_extract. Frames are
//               generated with $urandom; a reference model derives the band
//               sequence and residual directly from the matrix definition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bidiag_band_extract;

    localparam int BIT_NUM  = 18;
    localparam int DIM      = 4;
    localparam int NBEAT    = DIM * DIM;
    localparam int NBAND    = 2 * DIM - 1;
    localparam int RESID_TH = 64;
    localparam int MAG_MAX  = (1 << (BIT_NUM - 1)) - 1;

    localparam int RDY_ALWAYS = 0;
    localparam int RDY_RANDOM = 1;
    localparam int RDY_TOGGLE = 2;
    localparam int RDY_STALL  = 3;

    typedef struct {
        int r;
        int i;
        int tag;
        int last;
    } band_t;

    logic                      clk     = 1'b0;
    logic                      rst_n   = 1'b0;
    logic                      s_valid = 1'b0;
    logic                      m_ready = 1'b0;
    logic signed [BIT_NUM-1:0] s_r     = '0;
    logic signed [BIT_NUM-1:0] s_i     = '0;
    logic signed [BIT_NUM-1:0] m_r;
    logic signed [BIT_NUM-1:0] m_i;
    logic                      m_valid;
    logic [2:0]                m_tag;
    logic                      m_last;
    logic [BIT_NUM-2:0]        resid_max;
    logic                      resid_flag;
    logic                      frame_err;
    logic                      drop;

    int    n_checks   = 0;
    int    n_fail     = 0;
    band_t exp_q[$];
    int    exp_resid  = 0;
    int    fr_r[NBEAT];
    int    fr_i[NBEAT];
    int    n_xfer     = 0;
    int    n_drop     = 0;
    int    n_err      = 0;
    int    ready_mode = RDY_ALWAYS;
    int    ready_cnt  = 0;
    logic  prev_stall = 1'b0;
    int    prev_r, prev_i, prev_tag;

    always #5 clk = ~clk;

    bidiag_band_extract #(
        .BIT_NUM  (BIT_NUM),
        .DIM      (DIM),
        .RESID_TH (18'd64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_r        (s_r),
        .s_i        (s_i),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_r        (m_r),
        .m_i        (m_i),
        .m_tag      (m_tag),
        .m_last     (m_last),
        .resid_max  (resid_max),
        .resid_flag (resid_flag),
        .frame_err  (frame_err),
        .drop       (drop)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mag(input int x);
        int m;
        m = (x < 0) ? -x : x;
        return (m > MAG_MAX) ? MAG_MAX : m;
    endfunction

    // Reference: walk the matrix, queue band elements in row-major order and
    // take the max magnitude of everything the band should not carry.
    task automatic model_frame();
        int    pos;
        int    worst;
        int    row;
        int    col;
        band_t b;
        pos   = 0;
        worst = 0;
        for (int k = 0; k < NBEAT; k++) begin
            row = k / DIM;
            col = k % DIM;
            if (col == row || col == row + 1) begin
                b.r    = fr_r[k];
                b.i    = fr_i[k];
                b.tag  = pos;
                b.last = (pos == NBAND - 1) ? 1 : 0;
                exp_q.push_back(b);
                pos++;
                if (mag(fr_i[k]) > worst) worst = mag(fr_i[k]);
            end else begin
                if (mag(fr_r[k]) > worst) worst = mag(fr_r[k]);
                if (mag(fr_i[k]) > worst) worst = mag(fr_i[k]);
            end
        end
        exp_resid = worst;
    endtask

    task automatic gen_frame(input int mode);
        for (int k = 0; k < NBEAT; k++) begin
            if (mode == 0) begin
                fr_r[k] = int'($urandom_range(0, 2 * MAG_MAX + 1)) - (MAG_MAX + 1);
                fr_i[k] = int'($urandom_range(0, 2 * MAG_MAX + 1)) - (MAG_MAX + 1);
            end else begin
                fr_r[k] = int'($urandom_range(0, 140)) - 70;
                fr_i[k] = int'($urandom_range(0, 140)) - 70;
            end
        end
        if (mode == 2) begin
            fr_r[$urandom_range(0, NBEAT - 1)] = -(MAG_MAX + 1);
        end
    endtask

    task automatic send_frame(input int nbeats, input bit tail_low);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_r     = BIT_NUM'(fr_r[b]);
            s_i     = BIT_NUM'(fr_i[b]);
        end
        if (tail_low) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_r     = '0;
            s_i     = '0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, int'(m_valid), 0);
    endtask

    task automatic check_resid(input string tag);
        check_eq({tag, "_resid_max"}, int'(resid_max), exp_resid);
        check_eq({tag, "_resid_flag"}, int'(resid_flag), (exp_resid > RESID_TH) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_m_valid"}, int'(m_valid), 0);
        check_eq({tag, "_m_r"}, int'(m_r), 0);
        check_eq({tag, "_m_i"}, int'(m_i), 0);
        check_eq({tag, "_m_tag"}, int'(m_tag), 0);
        check_eq({tag, "_m_last"}, int'(m_last), 0);
        check_eq({tag, "_resid_max"}, int'(resid_max), 0);
        check_eq({tag, "_resid_flag"}, int'(resid_flag), 0);
        check_eq({tag, "_frame_err"}, int'(frame_err), 0);
        check_eq({tag, "_drop"}, int'(drop), 0);
    endtask

    // Downstream ready driver
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                RDY_ALWAYS: m_ready = 1'b1;
                RDY_RANDOM: m_ready = 1'($urandom_range(0, 1));
                RDY_TOGGLE: begin
                    m_ready = ((ready_cnt % 3) == 0);
                    ready_cnt++;
                end
                default:    m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard transfers, check stall stability, count pulses
    initial begin
        band_t b;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_valid", int'(m_valid), 1);
                    check_eq("stall_r", int'(m_r), prev_r);
                    check_eq("stall_i", int'(m_i), prev_i);
                    check_eq("stall_tag", int'(m_tag), prev_tag);
                end
                if (m_valid && m_ready) begin
                    n_xfer++;
                    check_eq("xfer_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        check_eq("xfer_r", int'(m_r), b.r);
                        check_eq("xfer_i", int'(m_i), b.i);
                        check_eq("xfer_tag", int'(m_tag), b.tag);
                        check_eq("xfer_last", int'(m_last), b.last);
                    end
                end
                if (drop) n_drop++;
                if (frame_err) n_err++;
                prev_stall = m_valid && !m_ready;
                prev_r     = int'(m_r);
                prev_i     = int'(m_i);
                prev_tag   = int'(m_tag);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_r[NBAND];
        int xfer0, drop0, err0, t;
        t1_r = '{1, 2, 6, 7, 11, 12, 16};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, continuous ready: exact latency and ordering
        ready_mode = RDY_ALWAYS;
        for (int k = 0; k < NBEAT; k++) begin
            fr_r[k] = k + 1;
            fr_i[k] = 0;
        end
        model_frame();
        check_eq("t1_idle_before", int'(m_valid), 0);
        send_frame(NBEAT, 1'b1);
        #1;
        check_eq("t1_latency", int'(m_valid), 1);
        for (int j = 0; j < NBAND; j++) begin
            check_eq("t1_tag", int'(m_tag), j);
            check_eq("t1_r", int'(m_r), t1_r[j]);
            check_eq("t1_last", int'(m_last), (j == NBAND - 1) ? 1 : 0);
            @(negedge clk);
            #1;
        end
        check_eq("t1_valid_fall", int'(m_valid), 0);
        check_eq("t1_resid_15", int'(resid_max), 15);
        check_resid("t1");
        wait_drain("t1");

        // Saturation of the most negative value, then the threshold boundary
        for (int k = 0; k < NBEAT; k++) begin
            fr_r[k] = 0;
            fr_i[k] = 0;
        end
        fr_r[4] = -(MAG_MAX + 1);
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t2a");
        check_eq("t2a_sat", int'(resid_max), MAG_MAX);
        check_resid("t2a");
        fr_r[4] = 63;
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t2b");
        check_resid("t2b");

        // Random frames under random backpressure
        ready_mode = RDY_RANDOM;
        for (int n = 0; n < 6; n++) begin
            gen_frame(n % 3);
            model_frame();
            send_frame(NBEAT, 1'b1);
            wait_drain("rand");
            check_resid("rand");
        end

        // Periodic stalls: exactly one transfer per band element
        ready_mode = RDY_TOGGLE;
        gen_frame(1);
        model_frame();
        xfer0 = n_xfer;
        send_frame(NBEAT, 1'b1);
        wait_drain("t3");
        check_eq("t3_xfer_count", n_xfer - xfer0, NBAND);
        check_resid("t3");

        // Short frame aborts without output or residual update
        ready_mode = RDY_ALWAYS;
        gen_frame(0);
        err0  = n_err;
        xfer0 = n_xfer;
        send_frame(9, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check_eq("t4_frame_err", n_err - err0, 1);
        check_eq("t4_no_xfer", n_xfer - xfer0, 0);
        check_resid("t4_held");
        gen_frame(1);
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t4_next");
        check_resid("t4_next");

        // Frame arriving while emission is stalled is dropped
        ready_mode = RDY_STALL;
        gen_frame(1);
        model_frame();
        drop0 = n_drop;
        err0  = n_err;
        send_frame(NBEAT, 1'b1);
        gen_frame(0);
        send_frame(NBEAT, 1'b1);
        repeat (3) @(negedge clk);
        ready_mode = RDY_ALWAYS;
        wait_drain("t5");
        check_eq("t5_drop", n_drop - drop0, 1);
        check_eq("t5_no_err", n_err - err0, 0);
        check_resid("t5");
        gen_frame(1);
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t5_next");
        check_resid("t5_next");

        // Back-to-back frame: emission ends while the burst is still active
        gen_frame(1);
        model_frame();
        drop0 = n_drop;
        send_frame(NBEAT, 1'b0);
        gen_frame(0);
        send_frame(NBEAT, 1'b1);
        wait_drain("t5b");
        check_eq("t5b_drop", n_drop - drop0, 1);
        check_resid("t5b");
        gen_frame(2);
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t5b_next");
        check_resid("t5b_next");

        // Asynchronous reset in the middle of emission
        ready_mode = RDY_ALWAYS;
        gen_frame(1);
        model_frame();
        send_frame(NBEAT, 1'b1);
        #1;
        t = 0;
        while (!(m_valid && m_tag == 3'd3) && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("t6_at_tag3", int'(m_tag), 3);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        exp_q.delete();
        exp_resid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        gen_frame(1);
        model_frame();
        send_frame(NBEAT, 1'b1);
        wait_drain("t6_next");
        check_resid("t6_next");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
